// File: rtl/parking_gate_controller.sv
// Parking gate controller: turns entry/exit sensor edges into single-cycle
// allocate/release requests to the slot manager and drives both barriers.
module parking_gate_controller #(
  parameter int BARRIER_CYCLES = 8,
  parameter int SETTLE_CYCLES  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       entry_sensor_i,
  input  logic       exit_sensor_i,
  input  logic [1:0] exit_slot_id_i,
  input  logic       slot_available_i,
  input  logic [1:0] allocated_slot_i,
  input  logic [1:0] exit_slot_i,
  output logic       alloc_req_o,
  output logic       free_req_o,
  output logic [1:0] exit_car_select_o,
  output logic       entry_gate_open_o,
  output logic       exit_gate_open_o,
  output logic [1:0] assigned_slot_o,
  output logic [1:0] released_slot_o,
  output logic       full_denied_o,
  output logic [7:0] entry_count_o,
  output logic [7:0] exit_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC,
    S_ALLOC_CAP,
    S_FREE,
    S_FREE_CAP,
    S_SETTLE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] settle_q, settle_d;

  logic       entry_sens_q, exit_sens_q;
  logic       entry_pend_q, exit_pend_q;
  logic [1:0] exit_id_q;
  logic [1:0] assigned_q, released_q;
  logic [7:0] entry_cnt_q, exit_cnt_q;
  logic       entry_gate_q, exit_gate_q;
  logic [7:0] entry_timer_q, exit_timer_q;

  logic       entry_rise, exit_rise;
  logic       alloc_req, free_req, full_denied, entry_cap, exit_cap;

  // A rise only counts when the lane is idle: no pending request and gate closed.
  assign entry_rise = entry_sensor_i & ~entry_sens_q & ~entry_pend_q & ~entry_gate_q;
  assign exit_rise  = exit_sensor_i  & ~exit_sens_q  & ~exit_pend_q  & ~exit_gate_q;

  // Sensor history; reset to 1 so a sensor already high at reset release is not an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_sens_q <= 1'b1;
      exit_sens_q  <= 1'b1;
    end else begin
      entry_sens_q <= entry_sensor_i;
      exit_sens_q  <= exit_sensor_i;
    end
  end

  // Pending flags set by accepted edges, cleared when the request is served or refused.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_pend_q <= 1'b0;
      exit_pend_q  <= 1'b0;
      exit_id_q    <= 2'd0;
    end else begin
      if (entry_rise) begin
        entry_pend_q <= 1'b1;
      end else if (entry_cap || full_denied) begin
        entry_pend_q <= 1'b0;
      end
      if (exit_rise) begin
        exit_pend_q <= 1'b1;
        exit_id_q   <= exit_slot_id_i;
      end else if (exit_cap) begin
        exit_pend_q <= 1'b0;
      end
    end
  end

  // Sequencer state and settle-delay counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      settle_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  // Next-state and request strobes; exit requests win over entry requests.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    alloc_req   = 1'b0;
    free_req    = 1'b0;
    full_denied = 1'b0;
    entry_cap   = 1'b0;
    exit_cap    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (exit_pend_q) begin
          state_d = S_FREE;
        end else if (entry_pend_q) begin
          if (slot_available_i) begin
            state_d = S_ALLOC;
          end else begin
            full_denied = 1'b1;
          end
        end
      end
      S_ALLOC: begin
        alloc_req = 1'b1;
        state_d   = S_ALLOC_CAP;
      end
      S_ALLOC_CAP: begin
        entry_cap = 1'b1;
        settle_d  = 4'(SETTLE_CYCLES - 1);
        state_d   = S_SETTLE;
      end
      S_FREE: begin
        free_req = 1'b1;
        state_d  = S_FREE_CAP;
      end
      S_FREE_CAP: begin
        exit_cap = 1'b1;
        settle_d = 4'(SETTLE_CYCLES - 1);
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture slot-manager answers and count completed passages (wrapping).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      assigned_q  <= 2'd0;
      released_q  <= 2'd0;
      entry_cnt_q <= 8'd0;
      exit_cnt_q  <= 8'd0;
    end else begin
      if (entry_cap) begin
        assigned_q  <= allocated_slot_i;
        entry_cnt_q <= entry_cnt_q + 8'd1;
      end
      if (exit_cap) begin
        released_q <= exit_slot_i;
        exit_cnt_q <= exit_cnt_q + 8'd1;
      end
    end
  end

  // Entry barrier: opens after capture, stays up until timer expired and lane clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_gate_q  <= 1'b0;
      entry_timer_q <= 8'd0;
    end else if (entry_cap) begin
      entry_gate_q  <= 1'b1;
      entry_timer_q <= 8'(BARRIER_CYCLES);
    end else begin
      if (entry_timer_q != 8'd0) begin
        entry_timer_q <= entry_timer_q - 8'd1;
      end
      if (entry_gate_q && entry_timer_q == 8'd0 && !entry_sensor_i) begin
        entry_gate_q <= 1'b0;
      end
    end
  end

  // Exit barrier: same behaviour as the entry barrier, on the exit lane.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exit_gate_q  <= 1'b0;
      exit_timer_q <= 8'd0;
    end else if (exit_cap) begin
      exit_gate_q  <= 1'b1;
      exit_timer_q <= 8'(BARRIER_CYCLES);
    end else begin
      if (exit_timer_q != 8'd0) begin
        exit_timer_q <= exit_timer_q - 8'd1;
      end
      if (exit_gate_q && exit_timer_q == 8'd0 && !exit_sensor_i) begin
        exit_gate_q <= 1'b0;
      end
    end
  end

  assign alloc_req_o       = alloc_req;
  assign free_req_o        = free_req;
  assign full_denied_o     = full_denied;
  assign exit_car_select_o = exit_id_q;
  assign entry_gate_open_o = entry_gate_q;
  assign exit_gate_open_o  = exit_gate_q;
  assign assigned_slot_o   = assigned_q;
  assign released_slot_o   = released_q;
  assign entry_count_o     = entry_cnt_q;
  assign exit_count_o      = exit_cnt_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Directed bench for parking_gate_controller: request pulses are logged by a
// monitor and matched against expected events queued when stimulus is driven.
module tb_parking_gate_controller;

  localparam int BARRIER = 8;
  localparam int SETTLE  = 2;

  localparam logic [1:0] EV_ALLOC = 2'd1;
  localparam logic [1:0] EV_FREE  = 2'd2;
  localparam logic [1:0] EV_FULL  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [1:0]  sel;
    logic [31:0] cyc;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       entry_sensor_i, exit_sensor_i;
  logic [1:0] exit_slot_id_i;
  logic       slot_available_i;
  logic [1:0] allocated_slot_i, exit_slot_i;
  logic       alloc_req_o, free_req_o;
  logic [1:0] exit_car_select_o;
  logic       entry_gate_open_o, exit_gate_open_o;
  logic [1:0] assigned_slot_o, released_slot_o;
  logic       full_denied_o;
  logic [7:0] entry_count_o, exit_count_o;

  int  compared = 0;
  int  mismatched = 0;
  int  cyc = 0;
  int  entryOpenCnt = 0;
  int  exitOpenCnt = 0;
  int  allocPulses = 0;
  int  freePulses = 0;
  bit  bothHigh = 1'b0;
  bit  logEvents = 1'b1;
  ev_t expQ[$];
  ev_t obsQ[$];

  parking_gate_controller #(
    .BARRIER_CYCLES(BARRIER),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .entry_sensor_i   (entry_sensor_i),
    .exit_sensor_i    (exit_sensor_i),
    .exit_slot_id_i   (exit_slot_id_i),
    .slot_available_i (slot_available_i),
    .allocated_slot_i (allocated_slot_i),
    .exit_slot_i      (exit_slot_i),
    .alloc_req_o      (alloc_req_o),
    .free_req_o       (free_req_o),
    .exit_car_select_o(exit_car_select_o),
    .entry_gate_open_o(entry_gate_open_o),
    .exit_gate_open_o (exit_gate_open_o),
    .assigned_slot_o  (assigned_slot_o),
    .released_slot_o  (released_slot_o),
    .full_denied_o    (full_denied_o),
    .entry_count_o    (entry_count_o),
    .exit_count_o     (exit_count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: logs request/deny pulses with their cycle and counts gate-open cycles.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (alloc_req_o === 1'b1) begin
        allocPulses++;
        if (logEvents) obsQ.push_back(mkEv(EV_ALLOC, 2'd0, cyc));
      end
      if (free_req_o === 1'b1) begin
        freePulses++;
        if (logEvents) obsQ.push_back(mkEv(EV_FREE, exit_car_select_o, cyc));
      end
      if (full_denied_o === 1'b1 && logEvents) obsQ.push_back(mkEv(EV_FULL, 2'd0, cyc));
      if (alloc_req_o === 1'b1 && free_req_o === 1'b1) bothHigh = 1'b1;
      if (entry_gate_open_o === 1'b1) entryOpenCnt++;
      if (exit_gate_open_o === 1'b1) exitOpenCnt++;
    end
  end

  function automatic ev_t mkEv(input logic [1:0] kind, input logic [1:0] sel, input int c);
    ev_t e;
    e.kind = kind;
    e.sel  = sel;
    e.cyc  = 32'(c);
    return e;
  endfunction

  task automatic applyStimulus(input logic entry, input logic exitS);
    entry_sensor_i = entry;
    exit_sensor_i  = exitS;
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkEvents(input string tag);
    ev_t e, o;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (obsQ.size() > 0) o = obsQ.pop_front();
      else o = '1;
      checkOutput(tag, 64'(o), 64'(e));
    end
    checkOutput({tag, "_extra"}, 64'(obsQ.size()), 64'd0);
    obsQ.delete();
  endtask

  initial begin
    int n;
    int allocBase, freeBase;
    rst_i = 1'b1;
    applyStimulus(1'b0, 1'b0);
    exit_slot_id_i   = 2'd0;
    slot_available_i = 1'b1;
    allocated_slot_i = 2'd0;
    exit_slot_i      = 2'd0;
    $display("[TB] start");

    // Reset state
    waitCycles(2);
    checkOutput("rst_gates", {entry_gate_open_o, exit_gate_open_o}, 64'd0);
    checkOutput("rst_reqs", {alloc_req_o, free_req_o, full_denied_o}, 64'd0);
    checkOutput("rst_counts", {entry_count_o, exit_count_o}, 64'd0);
    checkOutput("rst_slots", {exit_car_select_o, assigned_slot_o, released_slot_o}, 64'd0);
    rst_i = 1'b0;
    waitCycles(3);

    // Entry with space: alloc 2 cycles after rise, gate open BARRIER+1 cycles
    allocated_slot_i = 2'd2;
    entryOpenCnt = 0;
    n = cyc;
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(mkEv(EV_ALLOC, 2'd0, n + 2));
    waitCycles(3);
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkEvents("entry_alloc");
    checkOutput("entry_assigned", 64'(assigned_slot_o), 64'd2);
    checkOutput("entry_count1", 64'(entry_count_o), 64'd1);
    checkOutput("entry_gate_cycles", 64'(entryOpenCnt), 64'(BARRIER + 1));

    // Entry when full: one deny pulse, no gate, count unchanged
    slot_available_i = 1'b0;
    entryOpenCnt = 0;
    n = cyc;
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(mkEv(EV_FULL, 2'd0, n + 1));
    waitCycles(2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);
    checkEvents("full_denied");
    checkOutput("full_gate", 64'(entryOpenCnt), 64'd0);
    checkOutput("full_count", 64'(entry_count_o), 64'd1);
    slot_available_i = 1'b1;

    // Simultaneous entry and exit: exit served first, entry after settle
    allocated_slot_i = 2'd3;
    exit_slot_id_i   = 2'd1;
    exit_slot_i      = 2'd1;
    n = cyc;
    applyStimulus(1'b1, 1'b1);
    expQ.push_back(mkEv(EV_FREE, 2'd1, n + 2));
    expQ.push_back(mkEv(EV_ALLOC, 2'd0, n + 5 + SETTLE));
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(25);
    checkEvents("simultaneous");
    checkOutput("sim_assigned", 64'(assigned_slot_o), 64'd3);
    checkOutput("sim_released", 64'(released_slot_o), 64'd1);
    checkOutput("sim_counts", {entry_count_o, exit_count_o}, {48'd0, 8'd2, 8'd1});

    // Exit sensor held 20 cycles: one free_req, gate held until sensor falls
    exit_slot_id_i = 2'd2;
    exit_slot_i    = 2'd2;
    exitOpenCnt = 0;
    n = cyc;
    applyStimulus(1'b0, 1'b1);
    expQ.push_back(mkEv(EV_FREE, 2'd2, n + 2));
    waitCycles(20);
    applyStimulus(1'b0, 1'b0);
    waitCycles(15);
    checkEvents("exit_held");
    checkOutput("exit_gate_cycles", 64'(exitOpenCnt), 64'd17);
    checkOutput("exit_released", 64'(released_slot_o), 64'd2);
    checkOutput("exit_count2", 64'(exit_count_o), 64'd2);

    // Reset during ALLOC_CAP: immediate clear, no pulses until a new edge
    allocated_slot_i = 2'd0;
    entryOpenCnt = 0;
    n = cyc;
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(mkEv(EV_ALLOC, 2'd0, n + 2));
    waitCycles(3);
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_counts", {entry_count_o, exit_count_o}, 64'd0);
    checkOutput("midrst_gates", {entry_gate_open_o, exit_gate_open_o}, 64'd0);
    waitCycles(2);
    rst_i = 1'b0;
    waitCycles(10);
    checkEvents("midrst_events");
    checkOutput("midrst_gate_cycles", 64'(entryOpenCnt), 64'd0);
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    allocated_slot_i = 2'd1;
    n = cyc;
    applyStimulus(1'b1, 1'b0);
    expQ.push_back(mkEv(EV_ALLOC, 2'd0, n + 2));
    waitCycles(2);
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkEvents("postrst_entry");
    checkOutput("postrst_count", 64'(entry_count_o), 64'd1);
    checkOutput("postrst_assigned", 64'(assigned_slot_o), 64'd1);

    // Counter wrap: 255 paired passages, then one more exit
    logEvents = 1'b0;
    allocBase = allocPulses;
    freeBase  = freePulses;
    for (int i = 0; i < 255; i++) begin
      applyStimulus(1'b1, 1'b1);
      waitCycles(1);
      applyStimulus(1'b0, 1'b0);
      waitCycles(22);
    end
    checkOutput("wrap_entry", 64'(entry_count_o), 64'd0);
    checkOutput("wrap_exit_255", 64'(exit_count_o), 64'd255);
    checkOutput("wrap_alloc_pulses", 64'(allocPulses - allocBase), 64'd255);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitCycles(20);
    checkOutput("wrap_exit", 64'(exit_count_o), 64'd0);
    checkOutput("wrap_free_pulses", 64'(freePulses - freeBase), 64'd256);
    checkOutput("never_both_req", 64'(bothHigh), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 SHALL have parameter BARRIER_CYCLES, default 8, minimum cycles a gate stays open (range 2..255).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, idle cycles after each request before the next (range 2..15).
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 entry_sensor  in  1  car present at entry lane.
REQ-006 exit_sensor  in  1  car present at exit lane.
REQ-007 exit_slot_id  in  2  slot number read from the exiting car's ticket; sampled on exit_sensor rise.
REQ-008 slot_available  in  1  from slot manager; 1 = at least one free slot.
REQ-009 allocated_slot  in  2  from slot manager; valid the cycle after alloc_req.
REQ-010 exit_slot  in  2  from slot manager; valid the cycle after free_req.
REQ-011 alloc_req  out  1  single-cycle allocation request to slot manager.
REQ-012 free_req  out  1  single-cycle release request to slot manager.
REQ-013 exit_car_select  out  2  slot to release; held stable whenever free_req=1.
REQ-014 entry_gate_open / exit_gate_open  out  1 each  barrier drive, 1 = open.
REQ-015 assigned_slot  out  2  slot shown to entering driver.
REQ-016 released_slot  out  2  slot confirmed freed on last exit.
REQ-017 full_denied  out  1  single-cycle pulse when an entry is refused for lack of space.
REQ-018 entry_count / exit_count  out  8 each  completed entries/exits, modulo 256.

Function
REQ-019 Sensors SHALL be edge-detected with one registered stage; a rising edge sets entry_pend or exit_pend; a held-high sensor SHALL NOT generate repeat requests.
REQ-020 Rising edges SHALL be ignored while the corresponding gate is open or its pend flag is already set.
REQ-021 Request sequencer states: IDLE, ALLOC, ALLOC_CAP, FREE, FREE_CAP, SETTLE.
REQ-022 IDLE: exit_pend has priority over entry_pend; exit_pend -> FREE; else entry_pend with slot_available=1 -> ALLOC; entry_pend with slot_available=0 -> pulse full_denied, clear entry_pend, stay IDLE.
REQ-023 alloc_req and free_req SHALL never be 1 in the same cycle, and each SHALL be 1 for exactly one cycle per served request.
REQ-024 ALLOC: alloc_req=1 for one cycle -> ALLOC_CAP.
REQ-025 ALLOC_CAP: latch allocated_slot into assigned_slot, clear entry_pend, open entry gate, increment entry_count -> SETTLE.
REQ-026 FREE: exit_car_select = latched exit_slot_id, free_req=1 for one cycle -> FREE_CAP.
REQ-027 FREE_CAP: latch exit_slot into released_slot, clear exit_pend, open exit gate, increment exit_count -> SETTLE.
REQ-028 SETTLE: hold SETTLE_CYCLES cycles (lets slot_available update) -> IDLE; no requests issued.
REQ-029 Each gate SHALL have an independent 8-bit timer: on open, load BARRIER_CYCLES; gate closes on the first cycle the timer is 0 and the lane sensor is 0; timer SHALL saturate at 0.
REQ-030 Gate open SHALL be asserted from the cycle after ALLOC_CAP/FREE_CAP; an open gate SHALL NOT block the other lane's requests.
REQ-031 Simultaneous entry and exit rising edges: both pend flags set; exit served first, entry served after SETTLE.
REQ-032 Counters SHALL wrap 255 -> 0 without flag.
REQ-033 Request latency: alloc_req/free_req asserted 2 cycles after sensor rise when sequencer is IDLE.

Reset
REQ-034 On rst=1, immediately: sequencer IDLE, pend flags 0, timers 0, alloc_req=0, free_req=0, both gates closed, full_denied=0, exit_car_select=0, assigned_slot=0, released_slot=0, counts=0.
REQ-035 Reset mid-request SHALL abandon it; no request pulse SHALL be emitted after rst falls until a new sensor rising edge.
REQ-036 A sensor already high when rst falls SHALL NOT count as a rising edge.

Verification
REQ-037 Entry, slot_available=1, allocated_slot=2 -> one alloc_req pulse 2 cycles after sensor rise, assigned_slot=2, entry_gate_open>=8 cycles, entry_count=1.
REQ-038 Entry with slot_available=0 -> full_denied single pulse, no alloc_req, gate stays closed, entry_count unchanged.
REQ-039 Entry and exit sensors rise same cycle, exit_slot_id=1 -> free_req (exit_car_select=1) first, alloc_req >=SETTLE_CYCLES+2 cycles later, never both high.
REQ-040 Exit sensor held high 20 cycles -> exit_gate_open until sensor falls, exactly one free_req.
REQ-041 rst asserted in ALLOC_CAP -> gates closed, counts 0 immediately, no request pulses until new edge.
REQ-042 256 entries/exits -> entry_count and exit_count wrap to 0.
